// File: rtl/cabin_call_manager.sv
// -----------------------------------------------------------------------------
// cabin_call_manager
//
// Upstream stage of the cabin LED controller. Each passenger call button is
// debounced and a debounced press is latched as a pending call. A round-robin
// arbiter presents one pending call at a time to the crew panel and holds it
// until the crew acknowledges it.
//
// Optional build macro: CALL_ESCALATION_EN
//   Defined   - an ALERT timer drives `escalate` high once a presented call has
//               gone TIMEOUT_CYCLES cycles without acknowledgement.
//   Undefined - no timer is built and `escalate` is tied low.
//
// Ports:
//   clk           in   1          system clock, all logic on the rising edge
//   reset         in   1          synchronous, active-high reset
//   call_btn      in   NUM_SEATS  raw passenger buttons (1 = pressed), clk domain
//   crew_ack      in   1          crew acknowledges the presented call
//   call_pending  out  NUM_SEATS  latched outstanding calls, one bit per seat
//   active_valid  out  1          a call is being presented to the crew
//   active_id     out  ID_W       seat index of the presented call
//   chime         out  1          one-cycle pulse on each entry to ALERT
//   escalate      out  1          unacknowledged-call alarm
//
// Crew handshake: active_valid/active_id form the offer and crew_ack is the
// acceptance. The pair is consumed on the rising edge where active_valid=1 and
// crew_ack=1; active_id is stable for as long as active_valid stays high, and
// crew_ack has no effect while active_valid=0. After every consumed offer
// active_valid drops for at least one cycle before the next offer.
// -----------------------------------------------------------------------------
module cabin_call_manager #(
    parameter int NUM_SEATS       = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 50,
    parameter int ID_W            = $clog2(NUM_SEATS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_SEATS-1:0] call_btn,
    input  logic                 crew_ack,
    output logic [NUM_SEATS-1:0] call_pending,
    output logic                 active_valid,
    output logic [ID_W-1:0]      active_id,
    output logic                 chime,
    output logic                 escalate
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ALERT = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Debounce: a seat's level flips only after DEBOUNCE_CYCLES consecutive
    // samples disagree with it; any agreeing sample restarts the count.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0]     db_cnt [NUM_SEATS];
    logic [NUM_SEATS-1:0] db_level;
    logic [NUM_SEATS-1:0] db_level_d;
    logic [NUM_SEATS-1:0] db_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SEATS; i++) begin
                db_cnt[i] <= '0;
            end
            db_level   <= '0;
            db_level_d <= '0;
        end else begin
            for (int i = 0; i < NUM_SEATS; i++) begin
                if (call_btn[i] != db_level[i]) begin
                    if (db_cnt[i] == CNT_LAST) begin
                        db_level[i] <= ~db_level[i];
                        db_cnt[i]   <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
            db_level_d <= db_level;
        end
    end

    // Rise is seen the cycle after the debounced level goes high, so the
    // pending bit lands one edge after the debounced transition.
    assign db_rise = db_level & ~db_level_d;

    // -------------------------------------------------------------------------
    // Round-robin pick: first pending seat after last_served, wrapping.
    // -------------------------------------------------------------------------
    logic [ID_W-1:0] last_served;
    logic [ID_W-1:0] pick_id;
    logic            pick_found;
    int              pick_idx;

    always_comb begin
        pick_id    = '0;
        pick_found = 1'b0;
        pick_idx   = 0;
        for (int k = 1; k <= NUM_SEATS; k++) begin
            pick_idx = (int'(last_served) + k) % NUM_SEATS;
            if (!pick_found && call_pending[pick_idx]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(pick_idx);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Call-presentation FSM
    // -------------------------------------------------------------------------
    state_t               state;
    state_t               state_nxt;
    logic [NUM_SEATS-1:0] ack_clear;
    logic [NUM_SEATS-1:0] pending_nxt;
    logic                 active_valid_nxt;
    logic [ID_W-1:0]      active_id_nxt;
    logic                 chime_nxt;
    logic [ID_W-1:0]      last_served_nxt;

    always_comb begin
        state_nxt        = state;
        ack_clear        = '0;
        active_valid_nxt = active_valid;
        active_id_nxt    = active_id;
        chime_nxt        = 1'b0;
        last_served_nxt  = last_served;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt        = ALERT;
                    active_id_nxt    = pick_id;
                    active_valid_nxt = 1'b1;
                    chime_nxt        = 1'b1;
                end
            end
            ALERT: begin
                if (crew_ack) begin
                    ack_clear[active_id] = 1'b1;
                    last_served_nxt      = active_id;
                    active_valid_nxt     = 1'b0;
                    state_nxt            = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // A rise on the seat being acknowledged survives the clear.
        pending_nxt = (call_pending & ~ack_clear) | db_rise;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            call_pending <= '0;
            active_valid <= 1'b0;
            active_id    <= '0;
            chime        <= 1'b0;
            last_served  <= ID_W'(NUM_SEATS - 1);
        end else begin
            state        <= state_nxt;
            call_pending <= pending_nxt;
            active_valid <= active_valid_nxt;
            active_id    <= active_id_nxt;
            chime        <= chime_nxt;
            last_served  <= last_served_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Escalation timer
    // -------------------------------------------------------------------------
`ifdef CALL_ESCALATION_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);

    logic [TMR_W-1:0] alert_tmr;

    // Held at zero in IDLE, so it always starts from zero on entry to ALERT.
    always_ff @(posedge clk) begin
        if (reset) begin
            alert_tmr <= '0;
        end else if (state == IDLE) begin
            alert_tmr <= '0;
        end else if (alert_tmr != TMR_MAX) begin
            alert_tmr <= alert_tmr + TMR_W'(1);
        end
    end

    // Leaving ALERT on the ack edge drops escalate together with active_valid.
    assign escalate = (state == ALERT) && (alert_tmr == TMR_MAX);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign escalate       = 1'b0;
`endif

endmodule

// File: tb/tb_cabin_call_manager.sv
// -----------------------------------------------------------------------------
// tb_cabin_call_manager
//
// Directed scenarios followed by randomized traffic. Every cycle the outputs are
// compared against a reference model built from the behavioural rules:
// debounce as "time since the last agreeing sample", pending as a set, and the
// arbiter as a wrap-around scan from the last served seat.
// -----------------------------------------------------------------------------
module tb_cabin_call_manager;

    localparam int N    = 4;
    localparam int DB   = 4;
    localparam int TMO  = 50;
    localparam int ID_W = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    call_btn = '0;
    logic            crew_ack = 1'b0;
    logic [N-1:0]    call_pending;
    logic            active_valid;
    logic [ID_W-1:0] active_id;
    logic            chime;
    logic            escalate;

    cabin_call_manager #(
        .NUM_SEATS      (N),
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TMO),
        .ID_W           (ID_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .call_btn    (call_btn),
        .crew_ack    (crew_ack),
        .call_pending(call_pending),
        .active_valid(active_valid),
        .active_id   (active_id),
        .chime       (chime),
        .escalate    (escalate)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int       cyc = 0;
    bit [N-1:0] m_lvl;
    int       m_anchor [N];
    bit [N-1:0] m_rise;
    bit [N-1:0] m_pend;
    bit       m_alert;
    int       m_active;
    int       m_last;
    bit       m_chime;
    int       m_alert_len;
    bit       m_esc;

    int checks = 0;
    int passes = 0;
    int order_q[$];

    task automatic model_edge(input logic [N-1:0] b, input logic a, input logic r);
        bit [N-1:0] new_pend;
        bit [N-1:0] new_rise;
        if (r) begin
            m_lvl = '0;
            for (int i = 0; i < N; i++) m_anchor[i] = cyc;
            m_rise = '0;
            m_pend = '0;
            m_alert = 1'b0;
            m_active = 0;
            m_last = N - 1;
            m_chime = 1'b0;
            m_alert_len = 0;
        end else begin
            new_pend = m_pend;
            if (m_alert && a) new_pend[m_active] = 1'b0;
            new_pend = new_pend | m_rise;
            m_chime = 1'b0;
            if (!m_alert) begin
                for (int k = 1; k <= N; k++) begin
                    int s;
                    s = (m_last + k) % N;
                    if (!m_alert && m_pend[s]) begin
                        m_alert = 1'b1;
                        m_active = s;
                        m_chime = 1'b1;
                        m_alert_len = 0;
                    end
                end
            end else if (a) begin
                m_last = m_active;
                m_alert = 1'b0;
            end else begin
                m_alert_len++;
            end
            new_rise = '0;
            for (int i = 0; i < N; i++) begin
                if (b[i] == m_lvl[i]) begin
                    m_anchor[i] = cyc;
                end else if (cyc - m_anchor[i] >= DB) begin
                    m_lvl[i] = ~m_lvl[i];
                    m_anchor[i] = cyc;
                    if (m_lvl[i]) new_rise[i] = 1'b1;
                end
            end
            m_rise = new_rise;
            m_pend = new_pend;
        end
`ifdef CALL_ESCALATION_EN
        m_esc = m_alert && (m_alert_len >= TMO);
`else
        m_esc = 1'b0;
`endif
        cyc++;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic compare_model();
        check("pending", 32'(call_pending), 32'(m_pend));
        check("valid", 32'(active_valid), 32'(m_alert));
        if (m_alert) check("active_id", 32'(active_id), 32'(m_active));
        check("chime", 32'(chime), 32'(m_chime));
        check("escalate", 32'(escalate), 32'(m_esc));
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic [N-1:0] b, input logic a, input logic r);
        @(negedge clk);
        call_btn = b;
        crew_ack = a;
        reset    = r;
        @(posedge clk);
        model_edge(b, a, r);
        #1;
        compare_model();
        if (chime === 1'b1) order_q.push_back(int'(active_id));
    endtask

    task automatic serve_all(input int n_cycles);
        for (int k = 0; k < n_cycles; k++) begin
            cycle('0, m_alert && (m_alert_len >= 3), 1'b0);
        end
    endtask

    task automatic check_order(input string tag, input int e0, input int e1, input int e2);
        check({tag, "_count"}, 32'(order_q.size()), 32'd3);
        if (order_q.size() == 3) begin
            check({tag, "_0"}, 32'(order_q[0]), 32'(e0));
            check({tag, "_1"}, 32'(order_q[1]), 32'(e1));
            check({tag, "_2"}, 32'(order_q[2]), 32'(e2));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Test 1: reset 2 cycles, seat 1 held 10 cycles
        cycle('0, 1'b0, 1'b1);
        cycle('0, 1'b0, 1'b1);
        check("reset_pending", 32'(call_pending), 32'd0);
        check("reset_valid", 32'(active_valid), 32'd0);
        check("reset_id", 32'(active_id), 32'd0);
        check("reset_chime", 32'(chime), 32'd0);
        for (int k = 0; k < 10; k++) begin
            cycle(4'b0010, 1'b0, 1'b0);
            if (k == 3) check("t1_pend_e3", 32'(call_pending), 32'd0);
            if (k == 4) begin
                check("t1_pend_e4", 32'(call_pending), 32'b0010);
                check("t1_valid_e4", 32'(active_valid), 32'd0);
            end
            if (k == 5) begin
                check("t1_valid_e5", 32'(active_valid), 32'd1);
                check("t1_id_e5", 32'(active_id), 32'd1);
                check("t1_chime_e5", 32'(chime), 32'd1);
            end
            if (k == 6) check("t1_chime_e6", 32'(chime), 32'd0);
        end
        for (int k = 0; k < 6; k++) cycle('0, 1'b1, 1'b0);
        check("t1_cleared", 32'(call_pending), 32'd0);

        // Test 2: 3-cycle glitch is ignored
        for (int k = 0; k < 3; k++) cycle(4'b0001, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) cycle('0, 1'b0, 1'b0);
        check("t2_pend", 32'(call_pending), 32'd0);
        check("t2_valid", 32'(active_valid), 32'd0);

        // Test 3: seats 0,2,3 together from a fresh reset
        cycle('0, 1'b0, 1'b1);
        order_q.delete();
        for (int k = 0; k < 5; k++) cycle(4'b1101, 1'b0, 1'b0);
        serve_all(40);
        check_order("t3_order", 0, 2, 3);
        check("t3_pend_end", 32'(call_pending), 32'd0);

        // Test 4: seat 2 served, seats 1 and 3 arrive meanwhile -> 3 then 1
        order_q.delete();
        for (int k = 0; k < 7; k++) cycle(4'b0100, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) cycle(4'b1010, 1'b0, 1'b0);
        serve_all(40);
        check_order("t4_order", 2, 3, 1);

        // Test 5: reset during ALERT discards everything
        for (int k = 0; k < 7; k++) cycle(4'b1010, 1'b0, 1'b0);
        check("t5_pend_before", 32'(call_pending), 32'b1010);
        check("t5_valid_before", 32'(active_valid), 32'd1);
        cycle('0, 1'b0, 1'b1);
        check("t5_pend_reset", 32'(call_pending), 32'd0);
        check("t5_valid_reset", 32'(active_valid), 32'd0);
        check("t5_chime_reset", 32'(chime), 32'd0);
        for (int k = 0; k < 10; k++) cycle('0, 1'b0, 1'b0);
        check("t5_pend_after", 32'(call_pending), 32'd0);
        check("t5_valid_after", 32'(active_valid), 32'd0);

        // Test 6: long ALERT without ack, then ack
        for (int k = 0; k < 6; k++) cycle(4'b0001, 1'b0, 1'b0);
        for (int k = 0; k < 60; k++) cycle('0, 1'b0, 1'b0);
`ifdef CALL_ESCALATION_EN
        check("t6_escalate", 32'(escalate), 32'd1);
`else
        check("t6_escalate", 32'(escalate), 32'd0);
`endif
        cycle('0, 1'b1, 1'b0);
        check("t6_esc_ack", 32'(escalate), 32'd0);
        check("t6_valid_ack", 32'(active_valid), 32'd0);

        // Randomized traffic
        begin
            logic [N-1:0] b;
            b = '0;
            for (int k = 0; k < 1500; k++) begin
                if ($urandom_range(0, 7) == 0) b = N'($urandom_range(0, (1 << N) - 1));
                cycle(b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0));
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cabin_call_manager.md
Name: cabin_call_manager

Overview:
Upstream stage of the cabin LED controller. Debounces passenger call buttons and latches each press as a pending call. A round-robin arbiter presents one call at a time to the crew until it is acknowledged. `call_pending` drives the LED stage directly; `active_*`, `chime` and `escalate` go to the crew panel.

Parameters:
NUM_SEATS, 4, number of call buttons; width of button and pending vectors (2..16)
DEBOUNCE_CYCLES, 4, consecutive identical samples required to change a debounced level (>=2)
TIMEOUT_CYCLES, 50, cycles in ALERT without ack before escalation (used only with CALL_ESCALATION_EN)
ID_W, $clog2(NUM_SEATS), width of active_id

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
call_btn  input  NUM_SEATS  raw passenger buttons, 1 = pressed, asynchronous to nothing (already clk-domain)
crew_ack  input  1  crew acknowledges the active call; sampled only in ALERT
call_pending  output  NUM_SEATS  latched outstanding calls, one bit per seat, to LED stage
active_valid  output  1  a call is currently presented to crew
active_id  output  ID_W  seat index of presented call; valid when active_valid
chime  output  1  one-cycle pulse on each entry to ALERT
escalate  output  1  unacknowledged-call alarm (0 when feature compiled out)

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high on `reset`.
- Reset values:
  - `call_pending`=0, `active_valid`=0, `active_id`=0, `chime`=0, `escalate`=0.
  - Debounced levels=0, debounce counters=0, FSM=IDLE.
  - `last_served`=NUM_SEATS-1, so seat 0 has first priority.
- Reset mid-operation: discards all pending and active calls. A button still held after reset must re-debounce as a new press.
- Debounce, per seat:
  - Counter increments on each edge where raw `call_btn[i]` differs from the debounced level, and clears when they match.
  - The debounced level toggles on the edge where DEBOUNCE_CYCLES consecutive differing samples have been seen; the counter clears on that edge.
  - Pulses shorter than DEBOUNCE_CYCLES cycles are ignored.
- Pending latch:
  - A debounced 0->1 transition sets `call_pending[i]` on the next edge.
  - Debounced falling edges have no effect; a call stays pending after release.
  - A further press on an already-pending seat has no effect; there is no double count.
- Timing example: button high from edge e0 with DEBOUNCE_CYCLES=4.
  - Debounced level high after e3.
  - `call_pending` bit high after e4.
  - `active_valid` high after e5 if the FSM was IDLE.
- FSM states: IDLE, ALERT.
  - **IDLE:** if `call_pending`!=0, pick the first set bit scanning from `last_served`+1 upward, wrapping modulo NUM_SEATS. Register it into `active_id`, set `active_valid`=1, pulse `chime`=1 for exactly one cycle, go to ALERT. Otherwise stay. `crew_ack` is ignored in IDLE.
  - **ALERT:** hold `active_id` stable. On `crew_ack`=1: clear `call_pending[active_id]`, set `last_served`=`active_id`, set `active_valid`=0, go to IDLE.
- Arbitration: IDLE spends at least one cycle between calls, so back-to-back calls are served with one cycle of `active_valid`=0. New pending bits arriving during ALERT wait their turn.
- Simultaneous events:
  - If a debounced rise on seat `active_id` coincides with the ack edge, set wins: the bit remains 1 and the seat is re-served later in round-robin order.
  - Multiple seats rising on the same edge are all latched.
- `crew_ack` held high continuously: exactly one call is acknowledged per ALERT visit, with no skipping.

Optional Feature:
CALL_ESCALATION_EN
- Defined:
  - A cycle counter clears on entry to ALERT and increments each cycle in ALERT, saturating.
  - When the count reaches TIMEOUT_CYCLES, `escalate` goes to 1.
  - `escalate` holds until the ack edge (cleared together with `active_valid`) or reset.
- Undefined: no timer is built and `escalate` is tied 0.

Test Plan:
1. Reset held 2 cycles, then `call_btn`=4'b0010 held 10 cycles -> `call_pending`=4'b0010 after edge 4; `active_valid`=1 with `active_id`=1 after edge 5; `chime` high exactly 1 cycle.
2. `call_btn[0]` glitch high for 3 cycles -> `call_pending` stays 4'b0000, `active_valid` stays 0.
3. Presses on seats 0, 2, 3 latched together, ack each ALERT after 3 cycles -> service order 0, 2, 3; one idle cycle between calls; `call_pending` ends 4'b0000.
4. After serving seat 2, seats 1 and 3 pending -> next `active_id`=3 (round-robin from `last_served`+1); then 1.
5. `reset` asserted during ALERT with `call_pending`=4'b1010 -> next cycle all outputs 0; with buttons released, nothing re-appears.
6. CALL_ESCALATION_EN defined, no ack -> `escalate`=1 after 50 cycles in ALERT; ack -> `escalate` and `active_valid` both 0 on the same edge. Without the macro, `escalate` is always 0.
